// File: rtl/adc_capture_pkg.sv
// Shared types and sizing helpers for the ADC capture controller.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Ceiling log2; clogb2(1) is 0.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Beat counter wide enough for len*channels plus one spare bit.
  function automatic int beat_cnt_width(input int len_width, input int no_channels);
    return len_width + clogb2(no_channels) + 1;
  endfunction

  localparam int DEF_BEAT_CNT_WIDTH = beat_cnt_width(16, 4);

endpackage

// File: rtl/adc_capture_ctrl.sv
// Frame/trigger controller in front of the ADC-to-AXIS serializer: gates
// samples while capturing, counts overruns and marks the frame's last beat.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | config latched, waiting for trig_in rising edge
// CAPTURE | forwarding adc samples to the serializer
// DRAIN   | all samples taken, waiting for the last output beat
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int AXIS_WIDTH  = 32,
  parameter int NO_CHANNELS = 4,
  parameter int LEN_WIDTH   = 16,
  parameter int OVR_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              adc_valid,
  input  logic [AXIS_WIDTH*NO_CHANNELS-1:0] adc_data,
  output logic                              ser_in_valid,
  input  logic                              ser_in_ready,
  output logic [AXIS_WIDTH*NO_CHANNELS-1:0] ser_in_data,
  input  logic                              axis_tvalid,
  input  logic                              axis_tready,
  output logic                              axis_tlast,
  input  logic [LEN_WIDTH-1:0]              cfg_frame_len,
  input  logic                              cfg_trig_en,
  input  logic                              cfg_continuous,
  input  logic                              arm,
  input  logic                              abort,
  input  logic                              trig_in,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              cfg_err,
  output logic [OVR_WIDTH-1:0]              overrun_cnt
);

  localparam int BW = beat_cnt_width(LEN_WIDTH, NO_CHANNELS);

  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] len_q, len_nx;
  logic [LEN_WIDTH-1:0] sample_cnt, sample_cnt_nx, sample_cnt_inc;
  logic                 trig_en_q, trig_en_nx;
  logic                 cont_q, cont_nx;
  logic                 trig_d;
  logic [BW-1:0]        beat_cnt, beat_cnt_nx;
  logic [BW-1:0]        target, target_nx;
  logic [OVR_WIDTH-1:0] overrun_nx;
  logic                 cfg_err_nx;
  logic                 accept, drop, beat_hs, at_target, trig_rise, in_frame;

  // Index of the last beat for a frame of n samples.
  function automatic logic [BW-1:0] last_beat(input logic [LEN_WIDTH-1:0] n);
    return (BW'(n) * BW'(NO_CHANNELS)) - BW'(1);
  endfunction

  assign ser_in_data    = adc_data;
  assign in_frame       = (state == ST_CAPTURE) || (state == ST_DRAIN);
  assign accept         = (state == ST_CAPTURE) && adc_valid && ser_in_ready;
  assign drop           = (state == ST_CAPTURE) && adc_valid && !ser_in_ready;
  assign beat_hs        = in_frame && axis_tvalid && axis_tready;
  assign at_target      = (beat_cnt == target);
  assign trig_rise      = trig_in && !trig_d;
  assign sample_cnt_inc = sample_cnt + LEN_WIDTH'(accept);
  assign axis_tlast     = in_frame && at_target;
  assign busy           = (state != ST_IDLE);

  // Next-state, counter updates and combinational outputs.
  always_comb begin
    state_nx      = state;
    len_nx        = len_q;
    trig_en_nx    = trig_en_q;
    cont_nx       = cont_q;
    sample_cnt_nx = sample_cnt;
    beat_cnt_nx   = beat_cnt;
    target_nx     = target;
    overrun_nx    = overrun_cnt;
    cfg_err_nx    = 1'b0;
    frame_done    = 1'b0;
    ser_in_valid  = 1'b0;

    if (beat_hs) beat_cnt_nx = beat_cnt + BW'(1);

    case (state)
      ST_IDLE: begin
        if (arm && !abort) begin
          if (cfg_frame_len == '0) begin
            cfg_err_nx = 1'b1;
          end else begin
            len_nx        = cfg_frame_len;
            trig_en_nx    = cfg_trig_en;
            cont_nx       = cfg_continuous;
            sample_cnt_nx = '0;
            beat_cnt_nx   = '0;
            overrun_nx    = '0;
            target_nx     = last_beat(cfg_frame_len);
            state_nx      = cfg_trig_en ? ST_ARMED : ST_CAPTURE;
          end
        end
      end
      ST_ARMED: begin
        if (abort)          state_nx = ST_IDLE;
        else if (trig_rise) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        ser_in_valid = adc_valid;
        if (accept) sample_cnt_nx = sample_cnt_inc;
        if (drop && !(&overrun_cnt)) overrun_nx = overrun_cnt + OVR_WIDTH'(1);
        if (abort) begin
          // A sample accepted in the abort cycle still belongs to the frame.
          if (sample_cnt_inc == '0) begin
            state_nx = ST_IDLE;
          end else begin
            target_nx = last_beat(sample_cnt_inc);
            cont_nx   = 1'b0;
            state_nx  = ST_DRAIN;
          end
        end else if (accept && (sample_cnt == len_q - LEN_WIDTH'(1))) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat_hs && at_target) begin
          frame_done = 1'b1;
          if (cont_q) begin
            sample_cnt_nx = '0;
            beat_cnt_nx   = '0;
            state_nx      = trig_en_q ? ST_ARMED : ST_CAPTURE;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, configuration and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      trig_en_q   <= 1'b0;
      cont_q      <= 1'b0;
      trig_d      <= 1'b0;
      sample_cnt  <= '0;
      beat_cnt    <= '0;
      target      <= '0;
      overrun_cnt <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      len_q       <= len_nx;
      trig_en_q   <= trig_en_nx;
      cont_q      <= cont_nx;
      trig_d      <= trig_in;
      sample_cnt  <= sample_cnt_nx;
      beat_cnt    <= beat_cnt_nx;
      target      <= target_nx;
      overrun_cnt <= overrun_nx;
      cfg_err     <= cfg_err_nx;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: a queue-based serializer stand-in plus a
// sample-window reference model; a second instance checks overrun saturation.
module tb_adc_capture_ctrl;

  localparam int W   = 32;
  localparam int NCH = 4;
  localparam int LW  = 16;
  localparam int OW  = 16;
  localparam int DW  = W * NCH;

  logic          clk;
  logic          reset;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          ser_in_valid, ser_in_ready;
  logic [DW-1:0] ser_in_data;
  logic          axis_tvalid, axis_tready, axis_tlast;
  logic [LW-1:0] cfg_frame_len;
  logic          cfg_trig_en, cfg_continuous, arm, abort, trig_in;
  logic          busy, frame_done, cfg_err;
  logic [OW-1:0] overrun_cnt;

  logic          s_ser_in_valid, s_axis_tlast, s_busy, s_frame_done, s_cfg_err;
  logic [DW-1:0] s_ser_in_data;
  logic [3:0]    s_overrun_cnt;

  adc_capture_ctrl #(.AXIS_WIDTH(W), .NO_CHANNELS(NCH), .LEN_WIDTH(LW), .OVR_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
    .ser_in_valid(ser_in_valid), .ser_in_ready(ser_in_ready), .ser_in_data(ser_in_data),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(axis_tlast),
    .cfg_frame_len(cfg_frame_len), .cfg_trig_en(cfg_trig_en), .cfg_continuous(cfg_continuous),
    .arm(arm), .abort(abort), .trig_in(trig_in), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err), .overrun_cnt(overrun_cnt));

  adc_capture_ctrl #(.AXIS_WIDTH(W), .NO_CHANNELS(NCH), .LEN_WIDTH(LW), .OVR_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
    .ser_in_valid(s_ser_in_valid), .ser_in_ready(ser_in_ready), .ser_in_data(s_ser_in_data),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(s_axis_tlast),
    .cfg_frame_len(cfg_frame_len), .cfg_trig_en(cfg_trig_en), .cfg_continuous(cfg_continuous),
    .arm(arm), .abort(abort), .trig_in(trig_in), .busy(s_busy), .frame_done(s_frame_done),
    .cfg_err(s_cfg_err), .overrun_cnt(s_overrun_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] exp_q[$];
  logic [W-1:0]  beat_q[$];
  int            tlast_q[$];
  int beats_seen, frame_beats, fd_cnt, cerr_cnt;
  int model_drops, model_need, model_len;
  bit model_on, model_cont;
  bit valid_all, tready_rand;
  int valid_pct;

  // Serializer stand-in: takes a sample when ready, emits NCH beats.
  always @(posedge clk) begin
    if (reset) begin
      beat_q.delete();
      axis_tvalid  <= 1'b0;
      ser_in_ready <= 1'b1;
    end else begin
      if (axis_tvalid && axis_tready) void'(beat_q.pop_front());
      if (ser_in_valid && ser_in_ready) begin
        obs_q.push_back(ser_in_data);
        for (int c = 0; c < NCH; c++) beat_q.push_back(ser_in_data[c*W +: W]);
      end
      axis_tvalid  <= (beat_q.size() != 0);
      ser_in_ready <= (beat_q.size() <= NCH);
    end
  end

  // Reference model: while a capture window is open, take the first
  // model_need offered samples the serializer can accept; offered samples it
  // cannot accept are overruns. Frame ends are tracked by counting beats.
  always @(negedge clk) begin
    if (!reset) begin
      if (model_on) begin
        if (adc_valid && ser_in_ready) begin
          exp_q.push_back(adc_data);
          model_need--;
          if (model_need == 0) model_on = 1'b0;
        end else if (adc_valid) begin
          model_drops++;
        end
      end
      if (axis_tvalid && axis_tready) begin
        if (axis_tlast) tlast_q.push_back(beats_seen);
        beats_seen++;
        frame_beats++;
        if (model_cont && frame_beats == model_len * NCH) begin
          frame_beats = 0;
          model_on    = 1'b1;
          model_need  = model_len;
        end
      end
      if (frame_done) fd_cnt++;
      if (cfg_err) cerr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    adc_data  = {$urandom, $urandom, $urandom, $urandom};
    adc_valid = valid_all ? 1'b1 : ($urandom_range(0, 99) < valid_pct);
    if (tready_rand) axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_obs();
    obs_q.delete(); exp_q.delete(); tlast_q.delete();
    beats_seen = 0; frame_beats = 0; fd_cnt = 0; cerr_cnt = 0;
    model_drops = 0; model_on = 1'b0; model_need = 0; model_cont = 1'b0;
  endtask

  task automatic start(input int len, input bit trig_en, input bit cont);
    cfg_frame_len  = LW'(len);
    cfg_trig_en    = trig_en;
    cfg_continuous = cont;
    model_len      = len;
    model_cont     = cont;
    arm = 1'b1;
    cycle();
    arm = 1'b0;
    if (!trig_en) begin
      model_on   = 1'b1;
      model_need = len;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin cycle(); n++; end
    chk({tag, "_idle"}, busy, 1'b0);
    if (busy) begin
      reset = 1'b1; cycle(); reset = 1'b0;
    end
    repeat (3) cycle();
  endtask

  task automatic check_frame(input string tag, input int exp_n);
    int m;
    chk({tag, "_nsamp"}, obs_q.size(), exp_n);
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_data"}, obs_q[i], exp_q[i]);
    chk({tag, "_model_n"}, obs_q.size(), exp_q.size());
    chk({tag, "_beats"}, beats_seen, exp_n * NCH);
    chk({tag, "_tlast_n"}, tlast_q.size(), 1);
    chk({tag, "_tlast_pos"}, (tlast_q.size() > 0) ? tlast_q[0] : -1, exp_n * NCH - 1);
    chk({tag, "_frame_done"}, fd_cnt, 1);
    chk({tag, "_overrun"}, overrun_cnt, model_drops);
    chk({tag, "_overrun_sat"}, s_overrun_cnt, (model_drops > 15) ? 15 : model_drops);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit busy_any;
    reset = 1'b1; adc_valid = 1'b0; adc_data = '0; axis_tready = 1'b1;
    cfg_frame_len = '0; cfg_trig_en = 1'b0; cfg_continuous = 1'b0;
    arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
    valid_all = 1'b0; valid_pct = 0; tready_rand = 1'b0;
    clear_obs();
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    chk("rst_busy", busy, 1'b0);
    chk("rst_ser_in_valid", ser_in_valid, 1'b0);
    chk("rst_tlast", axis_tlast, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_overrun", overrun_cnt, 0);

    // Basic frame, immediate start.
    valid_all = 1'b1; clear_obs();
    start(4, 1'b0, 1'b0);
    wait_idle("basic", 300);
    check_frame("basic", 4);

    // Triggered start: level held high before arm must not start capture.
    trig_in = 1'b1; clear_obs();
    start(2, 1'b1, 1'b0);
    repeat (6) cycle();
    chk("trig_pre_samples", obs_q.size(), 0);
    chk("trig_pre_busy", busy, 1'b1);
    trig_in = 1'b0; cycle();
    trig_in = 1'b1; cycle();
    model_on = 1'b1; model_need = 2;
    wait_idle("trig", 300);
    check_frame("trig", 2);
    trig_in = 1'b0;

    // Downstream stall: overruns counted, frame length unchanged.
    clear_obs();
    start(3, 1'b0, 1'b0);
    axis_tready = 1'b0;
    repeat (20) cycle();
    axis_tready = 1'b1;
    wait_idle("ovr", 300);
    check_frame("ovr", 3);

    // Abort after two accepted samples truncates the frame.
    clear_obs();
    start(8, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() < 2 && n < 200) begin cycle(); n++; end
    abort = 1'b1; adc_valid = 1'b0;
    cycle();
    abort = 1'b0; model_on = 1'b0;
    wait_idle("abort2", 300);
    check_frame("abort2", 2);

    // Abort while armed.
    clear_obs();
    start(5, 1'b1, 1'b0);
    repeat (2) cycle();
    abort = 1'b1; cycle(); abort = 1'b0; cycle();
    chk("abort_armed_busy", busy, 1'b0);

    // Abort in capture with nothing accepted.
    valid_all = 1'b0; valid_pct = 0; adc_valid = 1'b0; clear_obs();
    start(5, 1'b0, 1'b0);
    repeat (3) cycle();
    abort = 1'b1; cycle(); abort = 1'b0; model_on = 1'b0;
    repeat (5) cycle();
    chk("abort0_busy", busy, 1'b0);
    chk("abort0_beats", beats_seen, 0);
    chk("abort0_tlast", tlast_q.size(), 0);
    chk("abort0_frame_done", fd_cnt, 0);

    // Continuous: two back-to-back frames, then abort with nothing pending.
    valid_all = 1'b1; clear_obs();
    start(2, 1'b0, 1'b1);
    n = 0;
    while (exp_q.size() < 4 && n < 300) begin cycle(); n++; end
    valid_all = 1'b0; adc_valid = 1'b0;
    n = 0;
    while (beats_seen < 16 && n < 300) begin cycle(); n++; end
    repeat (3) cycle();
    chk("cont_rearmed_busy", busy, 1'b1);
    abort = 1'b1; cycle(); abort = 1'b0; model_on = 1'b0; model_cont = 1'b0;
    repeat (3) cycle();
    chk("cont_busy", busy, 1'b0);
    chk("cont_nsamp", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size() && i < exp_q.size(); i++)
      chk("cont_data", obs_q[i], exp_q[i]);
    chk("cont_tlast_n", tlast_q.size(), 2);
    chk("cont_tlast0", (tlast_q.size() > 0) ? tlast_q[0] : -1, 7);
    chk("cont_tlast1", (tlast_q.size() > 1) ? tlast_q[1] : -1, 15);
    chk("cont_frame_done", fd_cnt, 2);
    chk("cont_overrun", overrun_cnt, model_drops);

    // Arm with zero length is rejected.
    clear_obs();
    cfg_frame_len = '0; arm = 1'b1; cycle(); arm = 1'b0;
    busy_any = 1'b0;
    repeat (3) begin cycle(); busy_any |= busy; end
    chk("len0_cfg_err", cerr_cnt, 1);
    chk("len0_busy", busy_any, 1'b0);

    // Randomized frames with random valid density and downstream stalls.
    for (int r = 0; r < 6; r++) begin
      valid_all = 1'b0; valid_pct = $urandom_range(40, 100); tready_rand = 1'b1;
      clear_obs();
      start($urandom_range(1, 6), 1'b0, 1'b0);
      n = model_len;
      wait_idle("rand", 600);
      check_frame("rand", n);
    end
    tready_rand = 1'b0; axis_tready = 1'b1;

    // Reset mid-frame returns the controller to idle.
    valid_all = 1'b1; clear_obs();
    start(6, 1'b0, 1'b0);
    repeat (5) cycle();
    reset = 1'b1; model_on = 1'b0;
    repeat (2) cycle();
    reset = 1'b0; adc_valid = 1'b0; valid_all = 1'b0;
    cycle();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_overrun", overrun_cnt, 0);
    chk("midrst_ser_in_valid", ser_in_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
